// File: rtl/pipe_hold_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hold_ctrl
//   Pipeline control source for the RV32 core. Produces the hold/flush enables
//   for the PC, IF/ID and ID/EX stage registers, and the PC redirect (jump).
//   Arbitrates EX jump requests, multi-cycle EX stalls, fetch-bus waits and
//   interrupt entry. A stage register with its hold asserted loads its bubble
//   value; hold on the PC means "keep the current PC".
//
// Parameters
//   AW         address width of jump / interrupt targets
//   FLUSH_CYC  cycles IF/ID is bubbled per redirect, redirect cycle included
//   STALL_MAX  consecutive hold-request cycles before stall_timeout_o rises
//
// Ports
//   clk              core clock, all state on posedge
//   rst              synchronous reset, active-high
//   jump_req_i       EX branch/jump taken this cycle
//   jump_addr_i      EX redirect target
//   ex_hold_req_i    multi-cycle EX op busy (level)
//   bus_hold_req_i   instruction fetch bus not ready (level)
//   int_req_i        interrupt request, held until int_ack_o
//   int_addr_i       interrupt vector, stable while int_req_i high
//   int_ack_o        one-cycle acceptance of int_req_i
//   jump_o           redirect PC this cycle
//   jump_addr_o      redirect target (valid when jump_o)
//   hold_pc_o        PC register keeps value
//   hold_if_o        IF/ID register loads bubble
//   hold_id_o        ID/EX register loads bubble
//   stall_timeout_o  sticky: stall reached STALL_MAX
// -----------------------------------------------------------------------------
module pipe_hold_ctrl #(
  parameter int AW        = 32,
  parameter int FLUSH_CYC = 2,
  parameter int STALL_MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_req_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          ex_hold_req_i,
  input  logic          bus_hold_req_i,
  input  logic          int_req_i,
  input  logic [AW-1:0] int_addr_i,
  output logic          int_ack_o,
  output logic          jump_o,
  output logic [AW-1:0] jump_addr_o,
  output logic          hold_pc_o,
  output logic          hold_if_o,
  output logic          hold_id_o,
  output logic          stall_timeout_o
);

  localparam int FCW = $clog2(FLUSH_CYC + 1);
  localparam int SCW = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_STALL
  } state_e;

  state_e         state_q,     state_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic           timeout_q,   timeout_d;

  logic any_hold;
  logic int_accept;
  logic redirect;

  assign any_hold   = ex_hold_req_i | bus_hold_req_i;
  // Interrupts are only taken from a fully quiet pipeline; otherwise the
  // request simply waits (it is held by the source until acknowledged).
  assign int_accept = int_req_i && (state_q == ST_IDLE) && !jump_req_i && !any_hold;
  assign redirect   = jump_req_i | int_accept;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    stall_cnt_d     = stall_cnt_q;
    timeout_d       = timeout_q;
    int_ack_o       = 1'b0;
    jump_o          = 1'b0;
    jump_addr_o     = '0;
    hold_pc_o       = 1'b0;
    hold_if_o       = 1'b0;
    hold_id_o       = 1'b0;
    stall_timeout_o = timeout_q;

    // Stall watchdog: counts consecutive hold-request cycles, saturating.
    if (any_hold) begin
      if (stall_cnt_q != SCW'(STALL_MAX)) stall_cnt_d = stall_cnt_q + SCW'(1);
      if (stall_cnt_d == SCW'(STALL_MAX)) timeout_d = 1'b1;
    end else begin
      stall_cnt_d = '0;
    end

    if (redirect) begin
      // Redirect cycle: PC must load the target, so the PC hold is dropped
      // even if a stall request is present; the stall applies next cycle.
      jump_o      = 1'b1;
      jump_addr_o = jump_req_i ? jump_addr_i : int_addr_i;
      int_ack_o   = int_accept;
      hold_if_o   = 1'b1;
      hold_id_o   = 1'b1;
      if (FLUSH_CYC > 1) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FCW'(FLUSH_CYC - 1);
      end else begin
        flush_cnt_d = '0;
        state_d     = any_hold ? ST_STALL : ST_IDLE;
      end
    end else begin
      hold_pc_o = any_hold;
      hold_if_o = any_hold;
      hold_id_o = ex_hold_req_i;
      if (state_q == ST_FLUSH) begin
        hold_if_o   = 1'b1;
        flush_cnt_d = flush_cnt_q - FCW'(1);
        if (flush_cnt_d == '0) state_d = any_hold ? ST_STALL : ST_IDLE;
        else                   state_d = ST_FLUSH;
      end else begin
        state_d = any_hold ? ST_STALL : ST_IDLE;
      end
    end

    // Reset dominates every output, including the combinational paths.
    if (rst) begin
      int_ack_o       = 1'b0;
      jump_o          = 1'b0;
      jump_addr_o     = '0;
      hold_pc_o       = 1'b0;
      hold_if_o       = 1'b0;
      hold_id_o       = 1'b0;
      stall_timeout_o = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hold_ctrl
//   Directed bench for pipe_hold_ctrl (FLUSH_CYC=2, STALL_MAX=4). Inputs are
//   changed 2 time units after each rising edge and outputs are checked 1 unit
//   later, well clear of the next edge. Flag vector order:
//   {int_ack, jump, hold_pc, hold_if, hold_id, stall_timeout}.
// -----------------------------------------------------------------------------
module tb_pipe_hold_ctrl;

  localparam int AW = 32;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] F_ACK = 6'b100000;
  localparam logic [5:0] F_JMP = 6'b010000;
  localparam logic [5:0] F_PC  = 6'b001000;
  localparam logic [5:0] F_IF  = 6'b000100;
  localparam logic [5:0] F_ID  = 6'b000010;
  localparam logic [5:0] F_TO  = 6'b000001;

  logic          clk;
  logic          rst;
  logic          jump_req_i;
  logic [AW-1:0] jump_addr_i;
  logic          ex_hold_req_i;
  logic          bus_hold_req_i;
  logic          int_req_i;
  logic [AW-1:0] int_addr_i;
  logic          int_ack_o;
  logic          jump_o;
  logic [AW-1:0] jump_addr_o;
  logic          hold_pc_o;
  logic          hold_if_o;
  logic          hold_id_o;
  logic          stall_timeout_o;

  int checks = 0;
  int errors = 0;

  pipe_hold_ctrl #(
    .AW       (AW),
    .FLUSH_CYC(2),
    .STALL_MAX(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_req_i     (jump_req_i),
    .jump_addr_i    (jump_addr_i),
    .ex_hold_req_i  (ex_hold_req_i),
    .bus_hold_req_i (bus_hold_req_i),
    .int_req_i      (int_req_i),
    .int_addr_i     (int_addr_i),
    .int_ack_o      (int_ack_o),
    .jump_o         (jump_o),
    .jump_addr_o    (jump_addr_o),
    .hold_pc_o      (hold_pc_o),
    .hold_if_o      (hold_if_o),
    .hold_id_o      (hold_id_o),
    .stall_timeout_o(stall_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits 1 unit for combinational settling, then compares flags and, when a
  // redirect is expected, the redirect target.
  task automatic chk(input string tag, input logic [5:0] exp, input logic [AW-1:0] exp_addr);
    logic [5:0] obs;
    #1;
    obs = {int_ack_o, jump_o, hold_pc_o, hold_if_o, hold_id_o, stall_timeout_o};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s flags observed=%b expected=%b", tag, obs, exp);
    end
    if (exp[4]) begin
      checks++;
      assert (jump_addr_o === exp_addr) else begin
        errors++;
        $error("FAIL %s addr observed=%h expected=%h", tag, jump_addr_o, exp_addr);
      end
    end
  endtask

  initial begin
    // ---- 1: reset with every request high -> outputs forced low ----
    rst = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h1234;
    ex_hold_req_i = 1'b1; bus_hold_req_i = 1'b1;
    int_req_i = 1'b1; int_addr_i = 32'h4000;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset_c%0d", i), NONE, '0);
    end
    rst = 1'b0; jump_req_i = 1'b0; ex_hold_req_i = 1'b0;
    bus_hold_req_i = 1'b0; int_req_i = 1'b0;
    chk("reset_release", NONE, '0);
    tick();
    chk("idle_after_reset", NONE, '0);

    // ---- 2: single jump, two-cycle flush ----
    tick();
    jump_req_i = 1'b1; jump_addr_i = 32'h80;
    chk("jump_c0", F_JMP | F_IF | F_ID, 32'h80);
    tick();
    jump_req_i = 1'b0;
    chk("jump_c1", F_IF, '0);
    tick();
    chk("jump_c2", NONE, '0);

    // jump during flush restarts the redirect
    tick();
    jump_req_i = 1'b1; jump_addr_i = 32'h100;
    chk("rejump_c0", F_JMP | F_IF | F_ID, 32'h100);
    tick();
    jump_addr_i = 32'h104;
    chk("rejump_in_flush", F_JMP | F_IF | F_ID, 32'h104);
    tick();
    jump_req_i = 1'b0;
    chk("rejump_flush", F_IF, '0);
    tick();
    chk("rejump_done", NONE, '0);

    // jump with ex_hold same cycle: jump wins, stall honoured next cycle
    tick();
    jump_req_i = 1'b1; jump_addr_i = 32'h200; ex_hold_req_i = 1'b1;
    chk("jump_ex_c0", F_JMP | F_IF | F_ID, 32'h200);
    tick();
    jump_req_i = 1'b0;
    chk("jump_ex_c1", F_PC | F_IF | F_ID, '0);
    tick();
    ex_hold_req_i = 1'b0;
    chk("jump_ex_c2", NONE, '0);

    // ---- 3: ex_hold 5 cycles (timeout after 4th), then bus_hold 3 ----
    tick();
    ex_hold_req_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("ex_hold_c%0d", k), F_PC | F_IF | F_ID | ((k == 5) ? F_TO : NONE), '0);
      tick();
    end
    ex_hold_req_i = 1'b0;
    chk("ex_hold_release", F_TO, '0);
    tick();
    rst = 1'b1;
    chk("rst_during_to", NONE, '0);
    tick();
    rst = 1'b0;
    chk("to_cleared", NONE, '0);
    tick();
    bus_hold_req_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("bus_hold_c%0d", k), F_PC | F_IF, '0);
      tick();
    end
    bus_hold_req_i = 1'b0;
    chk("bus_hold_release", NONE, '0);
    tick();

    // ---- 4: interrupt waits through stall and flush ----
    ex_hold_req_i = 1'b1; int_req_i = 1'b1; int_addr_i = 32'h2000;
    chk("int_in_ex_hold", F_PC | F_IF | F_ID, '0);
    tick();
    ex_hold_req_i = 1'b0; jump_req_i = 1'b1; jump_addr_i = 32'h300;
    chk("int_vs_jump", F_JMP | F_IF | F_ID, 32'h300);
    tick();
    jump_req_i = 1'b0;
    chk("int_in_flush", F_IF, '0);
    tick();
    chk("int_ack", F_ACK | F_JMP | F_IF | F_ID, 32'h2000);
    tick();
    int_req_i = 1'b0;
    chk("int_flush", F_IF, '0);
    tick();
    chk("int_done", NONE, '0);

    // request during a stall is not taken while fsm still in STALL
    tick();
    ex_hold_req_i = 1'b1; int_req_i = 1'b1; int_addr_i = 32'h440;
    chk("int2_ex", F_PC | F_IF | F_ID, '0);
    tick();
    ex_hold_req_i = 1'b0;
    chk("int2_stall_exit", NONE, '0);
    tick();
    jump_req_i = 1'b1; jump_addr_i = 32'h500;
    chk("int2_jump_wins", F_JMP | F_IF | F_ID, 32'h500);
    tick();
    jump_req_i = 1'b0;
    chk("int2_flush", F_IF, '0);
    tick();
    chk("int2_ack", F_ACK | F_JMP | F_IF | F_ID, 32'h440);
    tick();
    int_req_i = 1'b0;
    chk("int2_after_ack", F_IF, '0);
    tick();
    chk("int2_done", NONE, '0);

    // ---- 5: bus_hold exactly STALL_MAX cycles -> sticky timeout ----
    tick();
    bus_hold_req_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to_bus_c%0d", k), F_PC | F_IF, '0);
      tick();
    end
    bus_hold_req_i = 1'b0;
    chk("to_set", F_TO, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("to_sticky_%0d", k), F_TO, '0);
    end
    tick();
    rst = 1'b1;
    chk("to_rst_forced", NONE, '0);
    tick();
    rst = 1'b0;
    chk("to_rst_cleared", NONE, '0);

    // ---- 6: reset in flush cycle 1 leaves no residual bubble ----
    tick();
    jump_req_i = 1'b1; jump_addr_i = 32'h900;
    chk("rstflush_jump", F_JMP | F_IF | F_ID, 32'h900);
    tick();
    jump_req_i = 1'b0; rst = 1'b1;
    chk("rstflush_in_rst", NONE, '0);
    tick();
    rst = 1'b0;
    chk("rstflush_no_bubble", NONE, '0);
    tick();
    chk("rstflush_idle", NONE, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
